// File: rtl/tokenflow_rx_pkg.sv
// Shared definitions for the tokenflow receiver: default channel width,
// FSM state encoding and counter helpers.
package tokenflow_rx_pkg;

    localparam int TOKENFLOW_W   = 15;
    localparam int TOKEN_COUNT_W = 16;
    localparam int ERR_COUNT_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rx_state_e;

    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tokenflow_rx_fifo.sv
// W x DEPTH synchronous FIFO with a registered head word; full/empty come
// from log2(DEPTH)-bit pointers plus a wrap bit each.
module tokenflow_rx_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         srst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic          wr_wrap_q, rd_wrap_q;
    logic [W-1:0]  head_q, head_d;
    logic [AW:0]   rd_next;
    logic          do_push, do_pop, single;

    assign full_o  = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q != rd_wrap_q);
    assign empty_o = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q == rd_wrap_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rd_next = {rd_wrap_q, rd_ptr_q} + 1'b1;
    assign single  = ({wr_wrap_q, wr_ptr_q} == rd_next);
    assign head_o  = head_q;

    // The head register is loaded from the entry behind the one being popped,
    // or straight from the write port when that entry is the one arriving now.
    always_comb begin
        head_d = head_q;
        if (do_pop) begin
            if (!single) begin
                head_d = mem_q[rd_next[AW-1:0]];
            end else if (do_push) begin
                head_d = wdata_i;
            end
        end else if (do_push && empty_o) begin
            head_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_wrap_q <= 1'b0;
            rd_wrap_q <= 1'b0;
            head_q    <= '0;
        end else begin
            if (do_push) begin
                {wr_wrap_q, wr_ptr_q} <= {wr_wrap_q, wr_ptr_q} + 1'b1;
            end
            if (do_pop) begin
                {rd_wrap_q, rd_ptr_q} <= rd_next;
            end
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/tokenflow_rx.sv
// Receiver for the 4-phase bundled-data tokenflow channel: synchronises ch_req,
// captures ch_data into a FIFO and streams it out. Optional sequence checker
// is enabled with TOKENFLOW_RX_SEQ_CHECK_EN.
module tokenflow_rx
    import tokenflow_rx_pkg::*;
#(
    parameter int W           = TOKENFLOW_W,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ch_req,
    input  logic [W-1:0]             ch_data,
    output logic                     ch_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [TOKEN_COUNT_W-1:0] token_count
`ifdef TOKENFLOW_RX_SEQ_CHECK_EN
    ,
    output logic                     seq_err,
    output logic [ERR_COUNT_W-1:0]   err_count
`endif
);

    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     sreq;
    rx_state_e                state_q, state_d;
    logic                     ch_ack_q;
    logic [TOKEN_COUNT_W-1:0] token_count_q;
    logic                     push, pop;
    logic                     fifo_full, fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ch_req};
        end
    end

    assign sreq = sync_q[SYNC_STAGES-1];

    // Capture only from IDLE while there is room; a full FIFO simply leaves
    // the request unacknowledged so the sender stalls.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sreq && !fifo_full) begin
                    push    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!sreq) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ch_ack_q      <= 1'b0;
            token_count_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_ack_q <= (state_d == HOLD);
            if (push) begin
                token_count_q <= token_count_q + 1'b1;
            end
        end
    end

    assign pop = out_valid && out_ready;

    tokenflow_rx_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst_i  (reset),
        .push_i  (push),
        .wdata_i (ch_data),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (out_data)
    );

    assign ch_ack      = ch_ack_q;
    assign out_valid   = !fifo_empty;
    assign token_count = token_count_q;

`ifdef TOKENFLOW_RX_SEQ_CHECK_EN
    // Expected tokens follow x*(x+1): add a delta that itself grows by 2.
    logic [W-1:0]             exp_val_q, exp_delta_q;
    logic                     seq_err_q;
    logic [ERR_COUNT_W-1:0]   err_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_val_q   <= '0;
            exp_delta_q <= W'(2);
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
        end else if (push) begin
            if (ch_data != exp_val_q) begin
                seq_err_q   <= 1'b1;
                err_count_q <= sat_inc(err_count_q);
            end
            exp_val_q   <= exp_val_q + exp_delta_q;
            exp_delta_q <= exp_delta_q + W'(2);
        end
    end

    assign seq_err   = seq_err_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_tokenflow_rx.sv
// Self-checking bench for tokenflow_rx: a handshaking sender, a queue-based
// model of delivered tokens, and closed-form models of the counters.
module tb_tokenflow_rx;

    localparam int W     = 15;
    localparam int DEPTH = 4;
    localparam int SS    = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ch_req = 1'b0;
    logic [W-1:0] ch_data = '0;
    logic         out_ready = 1'b0;
    logic         ch_ack;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [15:0]  token_count;
`ifdef TOKENFLOW_RX_SEQ_CHECK_EN
    logic         seq_err;
    logic [7:0]   err_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];
    int  model_count = 0;
    int  model_idx = 0;
    int  model_err = 0;
    bit  model_seq_err = 1'b0;
    bit  rand_ready = 1'b0;

    tokenflow_rx #(.W(W), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_req      (ch_req),
        .ch_data     (ch_data),
        .ch_ack      (ch_ack),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .token_count (token_count)
`ifdef TOKENFLOW_RX_SEQ_CHECK_EN
        ,
        .seq_err     (seq_err),
        .err_count   (err_count)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] seq_val(input int x);
        longint v;
        v = longint'(x) * longint'(x + 1);
        return v[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
        exp_q.delete();
        model_count   = 0;
        model_idx     = 0;
        model_err     = 0;
        model_seq_err = 1'b0;
    endtask

    // Record a token the sender saw acknowledged and check the counters.
    task automatic model_accept(input logic [W-1:0] d);
        exp_q.push_back(d);
        model_count++;
        if (d != seq_val(model_idx)) begin
            model_seq_err = 1'b1;
            if (model_err < 255) model_err++;
        end
        model_idx++;
        check_eq("token_count", token_count, longint'(model_count) & 16'hFFFF);
`ifdef TOKENFLOW_RX_SEQ_CHECK_EN
        check_eq("seq_err", seq_err, model_seq_err);
        check_eq("err_count", err_count, model_err);
`endif
        $display("captured data=%h count=%0d", d, token_count);
    endtask

    task automatic wait_ack(input logic lvl, output int lat);
        lat = 0;
        while (ch_ack != lvl && lat < 200) begin
            tick();
            lat++;
        end
        if (ch_ack != lvl) check_eq("ack_wait_timeout", ch_ack, lvl);
    endtask

    task automatic send(input logic [W-1:0] d);
        int lat;
        ch_data = d;
        ch_req  = 1'b1;
        wait_ack(1'b1, lat);
        if (ch_ack) model_accept(d);
        ch_req = 1'b0;
        wait_ack(1'b0, lat);
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        tick();
        check_eq("drain_left", exp_q.size(), 0);
        check_eq("drain_valid", out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_pop", out_valid, 0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check_eq("out_data", out_data, e);
                $display("delivered data=%h", out_data);
            end
        end
    end

    initial begin
        int lat;
        int acks;
        logic [W-1:0] d;

        // Reset hold with ch_req toggling.
        for (int i = 0; i < 3; i++) begin
            ch_req = ~ch_req;
            tick();
            check_eq("rst_ack", ch_ack, 0);
            check_eq("rst_valid", out_valid, 0);
            check_eq("rst_count", token_count, 0);
        end
        check_eq("rst_data", out_data, 0);
        ch_req = 1'b0;
        do_reset(1);
        repeat (6) tick();

        // Single token: latency, no bypass, pop on arrival.
        ch_data   = W'(6);
        out_ready = 1'b1;
        ch_req    = 1'b1;
        lat = 0;
        while (!ch_ack && lat < 50) begin
            tick();
            lat++;
            if (lat == 2) check_eq("no_bypass_valid", out_valid, 0);
        end
        check_eq("req_to_ack_lat", lat, SS + 1);
        check_eq("valid_with_ack", out_valid, 1);
        check_eq("data_with_ack", out_data, 6);
        model_accept(W'(6));
        ch_req = 1'b0;
        wait_ack(1'b0, lat);
        check_eq("req_fall_to_ack_fall_lat", lat, SS + 1);
        tick();
        check_eq("single_count", token_count, 1);

        // Backpressure: four tokens fill the FIFO, the fifth stalls.
        do_reset(2);
        out_ready = 1'b0;
        for (int x = 0; x < DEPTH; x++) send(seq_val(x));
        ch_data = seq_val(4);
        ch_req  = 1'b1;
        acks = 0;
        repeat (8) begin
            tick();
            if (ch_ack) acks++;
        end
        check_eq("full_stall_ack", acks, 0);
        check_eq("full_valid", out_valid, 1);
        check_eq("full_count", token_count, DEPTH);
        out_ready = 1'b1;
        wait_ack(1'b1, lat);
        check_eq("resume_lat", lat, 2);
        if (ch_ack) model_accept(seq_val(4));
        ch_req = 1'b0;
        wait_ack(1'b0, lat);
        drain();
        check_eq("bp_count", token_count, 5);

        // Streaming 64 sequence tokens with the consumer always ready.
        do_reset(2);
        out_ready = 1'b1;
        for (int x = 0; x < 64; x++) send(seq_val(x));
        drain();
        check_eq("stream_count", token_count, 64);
`ifdef TOKENFLOW_RX_SEQ_CHECK_EN
        check_eq("stream_seq_err", seq_err, 0);
        check_eq("stream_err_count", err_count, 0);
`endif

        // One bad token in the sequence.
        do_reset(2);
        send(W'(0));
        send(W'(2));
        send(W'(7));
        send(W'(12));
        drain();
        check_eq("chk_count", token_count, 4);
`ifdef TOKENFLOW_RX_SEQ_CHECK_EN
        check_eq("chk_seq_err", seq_err, 1);
        check_eq("chk_err_count", err_count, 1);
`endif

        // Randomised data, gaps and consumer readiness.
        do_reset(2);
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 3) == 0) d = W'($urandom_range(0, (1 << W) - 1));
            else d = seq_val(model_idx);
            send(d);
        end
        drain();
        check_eq("rand_count", token_count, model_count);

        // Reset while in HOLD with two tokens buffered.
        do_reset(2);
        out_ready = 1'b0;
        send(W'(0));
        send(W'(2));
        ch_data = W'(6);
        ch_req  = 1'b1;
        wait_ack(1'b1, lat);
        check_eq("mid_hold_ack", ch_ack, 1);
        do_reset(1);
        check_eq("mid_rst_ack", ch_ack, 0);
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_count", token_count, 0);
        wait_ack(1'b1, lat);
        check_eq("recapture_lat", lat, SS + 1);
        if (ch_ack) model_accept(W'(6));
        ch_req = 1'b0;
        wait_ack(1'b0, lat);
        repeat (3) tick();
        check_eq("recapture_count", token_count, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
